apb_node_tmo: RTL and testbench
===============================

// Module: apb_node_tmo
// PURPOSE
//  Parametrised APB 1-to-NB_SLV interconnect node for the SoC peripheral subsystem.
//  Decodes each master transfer against a per-slave inclusive address window.
//  Forwards the transfer through a registered request/response stage.
//  Returns PSLVERR for unmapped addresses and for slaves that exceed a cycle timeout.
// PARAMETERS
//  NB_SLV          10   number of slave ports
//  APB_ADDR_WIDTH  32   PADDR width
//  APB_DATA_WIDTH  32   PWDATA/PRDATA width
//  TIMEOUT_CYCLES  256  max ACCESS cycles before error; 0 disables timeout
// PORTS
//  HCLK           in   1                    clock
//  HRESETn        in   1                    async active-low reset
//  m_paddr        in   APB_ADDR_WIDTH       master-side address
//  m_pwdata       in   APB_DATA_WIDTH       master-side write data
//  m_pwrite       in   1                    master-side write strobe
//  m_psel         in   1                    master-side select
//  m_penable      in   1                    master-side enable
//  m_prdata       out  APB_DATA_WIDTH       read data to master
//  m_pready       out  1                    ready to master
//  m_pslverr      out  1                    error to master
//  start_addr_i   in   NB_SLV*APB_ADDR_WIDTH  window start per slave (slice i = slave i)
//  end_addr_i     in   NB_SLV*APB_ADDR_WIDTH  window end per slave, inclusive
//  s_paddr        out  APB_ADDR_WIDTH       address to all slaves (registered)
//  s_pwdata       out  APB_DATA_WIDTH       write data to all slaves (registered)
//  s_pwrite       out  1                    write strobe to all slaves (registered)
//  s_penable      out  1                    enable to all slaves
//  s_psel         out  NB_SLV               one-hot select
//  s_prdata       in   NB_SLV*APB_DATA_WIDTH  per-slave read data
//  s_pready       in   NB_SLV               per-slave ready
//  s_pslverr      in   NB_SLV               per-slave error
// BEHAVIOUR
//  Reset
//   - HRESETn low (async): FSM=IDLE; all outputs 0; timeout counter 0; latched idx/data 0.
//   - Reset mid-transfer aborts the transfer silently; no response is issued.
//  Decode
//   - Slave i hits if start_i <= m_paddr <= end_i (unsigned).
//   - On overlap the lowest index wins; no hit = unmapped.
//  FSM
//   - IDLE:
//     - m_psel && !m_penable captures paddr/pwdata/pwrite and the decode result.
//     - Hit goes to SETUP; unmapped goes to RESP with err=1 and rdata=0.
//   - SETUP:
//     - s_psel[idx]=1 and s_penable=0 for one cycle, then ACCESS.
//   - ACCESS:
//     - s_psel[idx]=1 and s_penable=1; the counter increments each cycle.
//     - s_pready[idx]=1 latches s_prdata[idx] and s_pslverr[idx] (write: rdata=0), then RESP.
//     - Else if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: err=1, rdata=0, go RESP.
//     - On timeout, s_psel and s_penable drop the next cycle.
//   - RESP:
//     - m_pready=1 for exactly one cycle, with m_prdata/m_pslverr from the latches; then IDLE.
//     - Counter clears.
//  Outputs
//   - m_pready is 0 in every state except RESP; m_prdata and m_pslverr are 0 outside RESP.
//   - s_psel is all-zero in IDLE and RESP; at most one bit is ever set.
//   - s_paddr/s_pwdata/s_pwrite hold their last captured values outside a transfer.
//  Latency
//   - Master setup at cycle T, slave zero-wait: s_psel rises at T+1, s_penable at T+2, m_pready at T+3.
//   - Each slave wait state adds 1 cycle.
//   - Unmapped address: m_pready at T+1.
//  Boundary conditions
//   - Master inputs are ignored in SETUP, ACCESS and RESP.
//   - A master that drops m_psel early does not cancel the slave transfer.
//   - Back-to-back: a new setup is accepted only in IDLE; at least one IDLE cycle separates transfers.
//   - pready and timeout on the same cycle: pready wins, and slave data/err are used.
//   - start_i > end_i means the window is empty (never hits).
// TESTING
//  - Read 0x1A10_1004, slave1 window 0x1A10_1000-0x1A10_1FFF, zero-wait, prdata=0xCAFE0001
//    -> s_psel=0b10 at T+1; m_pready=1 and m_prdata=0xCAFE0001 at T+3; pslverr=0.
//  - Write 0x1A10_2000 data 0x55AA, slave2 3 wait states
//    -> s_pwdata=0x55AA and s_pwrite=1; m_pready at T+6; prdata=0.
//  - Access 0x1A20_0000 (unmapped)
//    -> no s_psel bit set; m_pready=1 with m_pslverr=1 at T+1; prdata=0.
//  - TIMEOUT_CYCLES=4, slave never ready
//    -> ACCESS lasts 4 cycles; s_psel drops; m_pslverr=1 one cycle later.
//  - Overlapping windows: slave0 and slave3 both cover 0x1A10_0010
//    -> only s_psel[0] asserts.
//  - HRESETn pulled low during ACCESS
//    -> all outputs 0 immediately; after release the next transfer completes normally.

Source files
------------

// File: rtl/apb_node_tmo.sv
// ---------------------------------------------------------------------------
// apb_node_tmo
//   APB 1-to-NB_SLV interconnect node. Each master transfer is decoded against
//   a per-slave inclusive address window and forwarded through a registered
//   request/response stage. Unmapped addresses and slaves that stay busy for
//   TIMEOUT_CYCLES ACCESS cycles are answered with PSLVERR.
//
// Ports
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   m_paddr/m_pwdata/m_pwrite/m_psel/m_penable
//                           master-side request
//   m_prdata/m_pready/m_pslverr
//                           master-side response (valid only in RESP)
//   start_addr_i/end_addr_i packed per-slave window bounds (slice i = slave i)
//   s_paddr/s_pwdata/s_pwrite
//                           captured request broadcast to all slaves
//   s_psel/s_penable        one-hot slave select and common enable
//   s_prdata/s_pready/s_pslverr
//                           packed per-slave response inputs
// ---------------------------------------------------------------------------
module apb_node_tmo #(
    parameter int NB_SLV         = 10,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,

    input  logic [APB_ADDR_WIDTH-1:0]        m_paddr,
    input  logic [APB_DATA_WIDTH-1:0]        m_pwdata,
    input  logic                             m_pwrite,
    input  logic                             m_psel,
    input  logic                             m_penable,
    output logic [APB_DATA_WIDTH-1:0]        m_prdata,
    output logic                             m_pready,
    output logic                             m_pslverr,

    input  logic [NB_SLV*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLV*APB_ADDR_WIDTH-1:0] end_addr_i,

    output logic [APB_ADDR_WIDTH-1:0]        s_paddr,
    output logic [APB_DATA_WIDTH-1:0]        s_pwdata,
    output logic                             s_pwrite,
    output logic                             s_penable,
    output logic [NB_SLV-1:0]                s_psel,
    input  logic [NB_SLV*APB_DATA_WIDTH-1:0] s_prdata,
    input  logic [NB_SLV-1:0]                s_pready,
    input  logic [NB_SLV-1:0]                s_pslverr
);

    localparam int IDX_W = (NB_SLV > 1) ? $clog2(NB_SLV) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt;

    // Address decode: scanning upward and keeping the first hit gives the
    // lowest index priority on overlapping windows. An inverted window
    // (start > end) can never satisfy both bounds, so it is naturally empty.
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int unsigned i = 0; i < NB_SLV; i++) begin
            if (!dec_hit &&
                (start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] <= m_paddr) &&
                (m_paddr <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    // Response of the slave currently owning the transfer.
    logic                      sel_ready;
    logic                      sel_err;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NB_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready = s_pready[i];
                sel_err   = s_pslverr[i];
                sel_rdata = s_prdata[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    // Counter value on the last permitted ACCESS cycle; a zero parameter
    // disables the timeout altogether.
    logic tmo_hit;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            idx_q     <= '0;
            cnt       <= '0;
            s_paddr   <= '0;
            s_pwdata  <= '0;
            s_pwrite  <= 1'b0;
            s_psel    <= '0;
            s_penable <= 1'b0;
            m_pready  <= 1'b0;
            m_prdata  <= '0;
            m_pslverr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_psel && !m_penable) begin
                        s_paddr  <= m_paddr;
                        s_pwdata <= m_pwdata;
                        s_pwrite <= m_pwrite;
                        idx_q    <= dec_idx;
                        if (dec_hit) begin
                            s_psel <= NB_SLV'(1) << dec_idx;
                            state  <= SETUP;
                        end else begin
                            m_pready  <= 1'b1;
                            m_pslverr <= 1'b1;
                            m_prdata  <= '0;
                            state     <= RESP;
                        end
                    end
                end

                SETUP: begin
                    s_penable <= 1'b1;
                    state     <= ACCESS;
                end

                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    // Ready is tested first so a slave answering on the
                    // timeout cycle still delivers its own data and error.
                    if (sel_ready) begin
                        s_psel    <= '0;
                        s_penable <= 1'b0;
                        m_pready  <= 1'b1;
                        m_pslverr <= sel_err;
                        m_prdata  <= s_pwrite ? '0 : sel_rdata;
                        state     <= RESP;
                    end else if (tmo_hit) begin
                        s_psel    <= '0;
                        s_penable <= 1'b0;
                        m_pready  <= 1'b1;
                        m_pslverr <= 1'b1;
                        m_prdata  <= '0;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    m_pready  <= 1'b0;
                    m_pslverr <= 1'b0;
                    m_prdata  <= '0;
                    cnt       <= '0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_node_tmo.sv
module tb_apb_node_tmo;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [AW-1:0]     m_paddr;
    logic [DW-1:0]     m_pwdata;
    logic              m_pwrite, m_psel, m_penable;
    logic [DW-1:0]     m_prdata;
    logic              m_pready, m_pslverr;
    logic [NS*AW-1:0]  start_addr, end_addr;
    logic [AW-1:0]     s_paddr;
    logic [DW-1:0]     s_pwdata;
    logic              s_pwrite, s_penable;
    logic [NS-1:0]     s_psel;
    logic [NS*DW-1:0]  s_prdata;
    logic [NS-1:0]     s_pready, s_pslverr;

    always #5 HCLK = ~HCLK;

    apb_node_tmo #(
        .NB_SLV(NS),
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
        .m_psel(m_psel), .m_penable(m_penable),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
        .start_addr_i(start_addr), .end_addr_i(end_addr),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
        .s_penable(s_penable), .s_psel(s_psel),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Slave responders: slave i raises pready after sw[i] wait cycles of
    // ACCESS; unselected slaves drive noise on pready that must be ignored.
    int            sw   [NS];
    logic [DW-1:0] srd  [NS];
    logic          serr [NS];
    logic [NS-1:0] noise = '0;
    int            acc_n = 0;

    always @(posedge HCLK) acc_n <= ((|s_psel) && s_penable) ? acc_n + 1 : 0;

    always_comb begin
        s_pready  = '0;
        s_prdata  = '0;
        s_pslverr = '0;
        for (int i = 0; i < NS; i++) begin
            s_prdata[i*DW +: DW] = srd[i];
            s_pslverr[i]         = serr[i];
            s_pready[i]          = s_psel[i] ? (s_penable && (acc_n == sw[i])) : noise[i];
        end
    end

    task automatic set_win(input int i, input logic [AW-1:0] s, input logic [AW-1:0] e);
        start_addr[i*AW +: AW] = s;
        end_addr[i*AW +: AW]   = e;
    endtask

    // Reference model: one transfer described by its setup cycle t0, the
    // decoded slave, the number of ACCESS cycles and the response it owes.
    bit            act = 1'b0;
    bit            m_hit;
    int            m_idx, t0, acc_len, resp_off, off;
    logic [DW-1:0] e_rd;
    logic          e_err;
    logic [AW-1:0] p_addr = '0, c_addr = '0;
    logic [DW-1:0] p_data = '0, c_data = '0;
    logic          p_wr = 1'b0, c_wr = 1'b0;

    function automatic int decode(input logic [AW-1:0] a);
        int r = -1;
        for (int i = 0; i < NS; i++)
            if (r < 0 && start_addr[i*AW +: AW] <= a && a <= end_addr[i*AW +: AW]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        act = 1'b0;
        p_addr = '0; c_addr = '0;
        p_data = '0; c_data = '0;
        p_wr = 1'b0; c_wr = 1'b0;
    endtask

    logic [NS-1:0] x_psel;
    logic          x_pen, x_rdy, x_err, x_wr;
    logic [DW-1:0] x_rd, x_data;
    logic [AW-1:0] x_addr;

    always @(negedge HCLK) begin
        if (mon_en) begin
            x_psel = '0; x_pen = 1'b0; x_rdy = 1'b0; x_rd = '0; x_err = 1'b0;
            x_addr = '0; x_data = '0; x_wr = 1'b0;
            if (HRESETn) begin
                x_addr = p_addr; x_data = p_data; x_wr = p_wr;
                if (act) begin
                    off = cyc - t0;
                    if (off >= 1) begin
                        x_addr = c_addr; x_data = c_data; x_wr = c_wr;
                    end
                    if (m_hit && off >= 1 && off <= acc_len + 1) x_psel = NS'(1) << m_idx;
                    if (m_hit && off >= 2 && off <= acc_len + 1) x_pen = 1'b1;
                    if (off == resp_off) begin
                        x_rdy = 1'b1; x_rd = e_rd; x_err = e_err;
                    end
                end
            end
            chk("m_pready",  32'(m_pready),  32'(x_rdy));
            chk("m_prdata",  m_prdata,       x_rd);
            chk("m_pslverr", 32'(m_pslverr), 32'(x_err));
            chk("s_psel",    32'(s_psel),    32'(x_psel));
            chk("s_penable", 32'(s_penable), 32'(x_pen));
            chk("s_paddr",   s_paddr,        x_addr);
            chk("s_pwdata",  s_pwdata,       x_data);
            chk("s_pwrite",  32'(s_pwrite),  32'(x_wr));
        end
    end

    task automatic start_xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        int ix, wt;
        @(posedge HCLK); #1;
        m_paddr = a; m_pwdata = d; m_pwrite = w; m_psel = 1'b1; m_penable = 1'b0;
        p_addr = c_addr; p_data = c_data; p_wr = c_wr;
        c_addr = a; c_data = d; c_wr = w;
        t0 = cyc;
        ix = decode(a);
        m_hit = (ix >= 0);
        m_idx = m_hit ? ix : 0;
        if (!m_hit) begin
            acc_len = 0; resp_off = 1; e_rd = '0; e_err = 1'b1;
        end else begin
            wt = sw[ix];
            if (wt < TO) begin
                acc_len = wt + 1; e_err = serr[ix]; e_rd = w ? '0 : srd[ix];
            end else begin
                acc_len = TO; e_err = 1'b1; e_rd = '0;
            end
            resp_off = acc_len + 2;
        end
        act = 1'b1;
    endtask

    // Drives the master for the rest of the transfer. In drop mode the master
    // releases psel or fakes new setups; otherwise it holds penable while
    // scrambling address/data. The node must ignore both.
    task automatic finish_xfer(input bit drop, output int lat, output logic [DW-1:0] rd,
                               output logic er, output logic [NS-1:0] ps1, output logic [NS-1:0] psr);
        bit done;
        done = 1'b0; lat = -1; rd = '0; er = 1'b0; ps1 = '0; psr = '0;
        for (int n = 0; n < 24 && !done; n++) begin
            @(posedge HCLK); #1;
            if (cyc - t0 == 1) ps1 = s_psel;
            if (m_pready) begin
                done = 1'b1; lat = cyc - t0; rd = m_prdata; er = m_pslverr; psr = s_psel;
            end else if (drop) begin
                m_psel = 1'($urandom); m_penable = 1'b0;
                m_paddr = $urandom; m_pwdata = $urandom; m_pwrite = 1'($urandom);
            end else begin
                m_penable = 1'b1; m_paddr = $urandom; m_pwdata = $urandom;
            end
        end
        chk("resp_within_bound", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK); #1;
            m_psel = 1'b0; m_penable = 1'b0;
        end
    endtask

    int            lat;
    logic [DW-1:0] rd;
    logic          er;
    logic [NS-1:0] ps1, psr;
    logic [AW-1:0] bnd [7];
    logic [AW-1:0] a;

    initial begin
        HRESETn = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
        set_win(0, 32'h1A10_0000, 32'h1A10_0FFF);
        set_win(1, 32'h1A10_1000, 32'h1A10_1FFF);
        set_win(2, 32'h1A10_2000, 32'h1A10_2FFF);
        set_win(3, 32'h1A10_0010, 32'h1A10_3FFF);
        for (int i = 0; i < NS; i++) begin
            sw[i] = 0; srd[i] = '0; serr[i] = 1'b0;
        end
        bnd = '{32'h1A0F_FFFF, 32'h1A10_4000, 32'h1A10_0FFF, 32'h1A10_1000,
                32'h1A10_3FFF, 32'h1A10_0010, 32'h1A10_000F};
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        mon_en = 1'b1;
        @(posedge HCLK); #1;
        chk("reset_pready", 32'(m_pready), 32'd0);
        chk("reset_psel",   32'(s_psel),   32'd0);
        chk("reset_paddr",  s_paddr,       32'd0);

        // zero-wait read from slave1
        sw[1] = 0; srd[1] = 32'hCAFE_0001; serr[1] = 1'b0;
        start_xfer(32'h1A10_1004, 32'h0, 1'b0);
        finish_xfer(1'b0, lat, rd, er, ps1, psr);
        chk("rd_psel_t1", 32'(ps1), 32'h2);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data",    rd,       32'hCAFE_0001);
        chk("rd_err",     32'(er),  32'd0);
        idle(1);

        // write to slave2 with 3 wait states (ready on the timeout cycle)
        sw[2] = 3; srd[2] = 32'hDEAD_BEEF; serr[2] = 1'b0;
        start_xfer(32'h1A10_2000, 32'h55AA, 1'b1);
        finish_xfer(1'b0, lat, rd, er, ps1, psr);
        chk("wr_latency", 32'(lat),      32'd6);
        chk("wr_rdata",   rd,            32'd0);
        chk("wr_err",     32'(er),       32'd0);
        chk("wr_pwdata",  s_pwdata,      32'h55AA);
        chk("wr_pwrite",  32'(s_pwrite), 32'd1);
        idle(2);

        // unmapped
        start_xfer(32'h1A20_0000, 32'h0, 1'b0);
        finish_xfer(1'b0, lat, rd, er, ps1, psr);
        chk("um_latency", 32'(lat), 32'd1);
        chk("um_err",     32'(er),  32'd1);
        chk("um_rdata",   rd,       32'd0);
        chk("um_psel",    32'(ps1), 32'd0);
        idle(1);

        // timeout: slave0 never ready
        sw[0] = 255; srd[0] = 32'h1234_5678; serr[0] = 1'b0;
        start_xfer(32'h1A10_0400, 32'h0, 1'b0);
        finish_xfer(1'b1, lat, rd, er, ps1, psr);
        chk("to_latency",   32'(lat), 32'd6);
        chk("to_err",       32'(er),  32'd1);
        chk("to_rdata",     rd,       32'd0);
        chk("to_psel_resp", 32'(psr), 32'd0);
        idle(1);

        // overlap: slave0 and slave3 both cover, lowest index wins
        sw[0] = 0; srd[0] = 32'h0000_0A0A;
        start_xfer(32'h1A10_0010, 32'h0, 1'b0);
        finish_xfer(1'b0, lat, rd, er, ps1, psr);
        chk("ov_psel", 32'(ps1), 32'h1);
        chk("ov_data", rd,       32'h0000_0A0A);

        // reset during ACCESS
        sw[0] = 255;
        start_xfer(32'h1A10_0020, 32'h0, 1'b0);
        @(posedge HCLK); #1; m_penable = 1'b1;
        @(posedge HCLK); #1;
        chk("rst_in_access", 32'(s_penable), 32'd1);
        #1 HRESETn = 1'b0;
        model_reset();
        #1;
        chk("rst_psel",    32'(s_psel),    32'd0);
        chk("rst_penable", 32'(s_penable), 32'd0);
        chk("rst_paddr",   s_paddr,        32'd0);
        chk("rst_pready",  32'(m_pready),  32'd0);
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge HCLK); @(posedge HCLK);
        #3 HRESETn = 1'b1;
        sw[0] = 0; srd[0] = 32'h0BAD_F00D;
        start_xfer(32'h1A10_0024, 32'h0, 1'b0);
        finish_xfer(1'b0, lat, rd, er, ps1, psr);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_data",    rd,       32'h0BAD_F00D);
        idle(1);

        // randomized traffic
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < NS; i++) begin
                sw[i] = $urandom_range(0, 5); srd[i] = $urandom; serr[i] = 1'($urandom);
            end
            noise = NS'($urandom);
            if (k % 40 == 20) set_win(2, 32'h1A10_2FFF, 32'h1A10_2000);
            if (k % 40 == 39) set_win(2, 32'h1A10_2000, 32'h1A10_2FFF);
            case ($urandom_range(0, 9))
                7:       a = bnd[$urandom_range(0, 6)];
                8, 9:    a = $urandom;
                default: a = 32'h1A10_0000 + (32'($urandom_range(0, 3)) << 12)
                             + 32'($urandom_range(0, 4095));
            endcase
            start_xfer(a, $urandom, 1'($urandom));
            finish_xfer(($urandom % 4) == 0, lat, rd, er, ps1, psr);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
